div_issue_ctrl: RTL

- Sequential issue/capture stage directly upstream of the team's combinational 32/16 divider.
- Buffers divide requests in a small FIFO using a valid/ready handshake.
- Drives the divider operands from registers and holds them stable for a fixed multicycle window, then captures quotient and remainder into an output register with valid/ready.
- Handles divide-by-zero itself; a zero-divisor request never waits on the divider.

---
 rtl/div_pkg.sv | 30 +++
 rtl/div_req_fifo.sv | 59 +++++
 rtl/div_issue_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the divider issue/capture stage.
// Used by div_req_fifo and div_issue_ctrl.
package div_pkg;

  localparam int DIV_A_W       = 32;
  localparam int DIV_B_W       = 16;
  localparam int DIV_R_W       = 32;
  // Widest tag a request entry can carry; the top zero-extends its TAG_W tag into it.
  localparam int DIV_TAG_MAX_W = 16;

  localparam logic [DIV_A_W-1:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    DONE
  } div_state_t;

  typedef struct packed {
    logic [DIV_A_W-1:0]       a;
    logic [DIV_B_W-1:0]       b;
    logic [DIV_TAG_MAX_W-1:0] tag;
  } div_req_t;

  // A zero divisor is resolved locally and never reaches the divider.
  function automatic logic req_is_dbz(input div_req_t req);
    return (req.b == '0);
  endfunction

endpackage

// File: rtl/div_req_fifo.sv
// Request FIFO for the divider issue stage.
// Power-of-two depth, pointer wrap modulo DEPTH, extra pointer bit separates full/empty.
// Head entry is read combinationally so a popped entry can be consumed in the same cycle.
module div_req_fifo
  import div_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  div_req_t din,
  input  logic     pop,
  output div_req_t dout,
  output logic     full,
  output logic     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   wr_ptr_reg;
  logic [PTR_W:0]   rd_ptr_reg;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] rd_idx;
  logic             do_push;
  logic             do_pop;
  div_req_t         mem [DEPTH];

  assign wr_idx  = wr_ptr_reg[PTR_W-1:0];
  assign rd_idx  = rd_ptr_reg[PTR_W-1:0];
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) && (wr_idx == rd_idx);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_idx];

  // Storage array: written at the tail, no reset needed since flags gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= din;
    end
  end

  // Read/write pointers; simultaneous push and pop leaves occupancy unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue/capture stage in front of the combinational 32/16 divider.
// Queues requests, holds divider operands stable for MC_CYCLES cycles, captures the
// result into an output register with valid/ready. Zero divisors bypass the divider.
// Optional feature: define DIV_REM_CHECK_EN to add the sticky rem_err remainder check.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MC_CYCLES = 3,
  parameter int TAG_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DIV_A_W-1:0] in_a,
  input  logic [DIV_B_W-1:0] in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic [DIV_A_W-1:0] div_a,
  output logic [DIV_B_W-1:0] div_b,
  input  logic [DIV_A_W-1:0] div_q,
  input  logic [DIV_R_W-1:0] div_r,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DIV_A_W-1:0] out_q,
  output logic [DIV_R_W-1:0] out_r,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_dbz
`ifdef DIV_REM_CHECK_EN
  ,
  output logic               rem_err
`endif
);

  // Counter only needs to hold MC_CYCLES-1.
  localparam int CNT_W = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_CYCLES - 1);

  div_state_t         state_reg;
  div_state_t         state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [DIV_A_W-1:0] div_a_reg;
  logic [DIV_B_W-1:0] div_b_reg;
  logic [TAG_W-1:0]   tag_reg;
  logic [DIV_A_W-1:0] out_q_reg;
  logic [DIV_R_W-1:0] out_r_reg;
  logic [TAG_W-1:0]   out_tag_reg;
  logic               out_dbz_reg;

  div_req_t req_in;
  div_req_t head_req;
  logic     fifo_full;
  logic     fifo_empty;
  logic     fifo_push;
  logic     fifo_pop;
  logic     take;
  logic     load_op;
  logic     load_dbz;
  logic     capture;

  // Upper tag bits of a queued entry are always zero-extension padding.
  logic     unused_tag_bits;
  assign unused_tag_bits = ^head_req.tag;

  // Pack the incoming request into a queue entry.
  always_comb begin
    req_in     = '0;
    req_in.a   = in_a;
    req_in.b   = in_b;
    req_in.tag = DIV_TAG_MAX_W'(in_tag);
  end

  assign fifo_push = in_valid && !fifo_full;

  div_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (req_in),
    .pop   (fifo_pop),
    .dout  (head_req),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state logic; DONE with a handshake pops the next request directly.
  always_comb begin
    state_next = state_reg;
    take       = 1'b0;
    fifo_pop   = 1'b0;
    load_op    = 1'b0;
    load_dbz   = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        take = !fifo_empty;
      end
      HOLD: begin
        if (cnt_reg == '0) begin
          capture    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (!fifo_empty) begin
            take = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (take) begin
      fifo_pop = 1'b1;
      if (req_is_dbz(head_req)) begin
        load_dbz   = 1'b1;
        state_next = DONE;
      end else begin
        load_op    = 1'b1;
        state_next = HOLD;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Multicycle hold counter: loaded on issue, counts down while holding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load_op) begin
      cnt_reg <= CNT_LOAD;
    end else if ((state_reg == HOLD) && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  // Divider operands change only on issue so the divider stays quiet otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_a_reg <= '0;
      div_b_reg <= '0;
      tag_reg   <= '0;
    end else if (load_op) begin
      div_a_reg <= head_req.a;
      div_b_reg <= head_req.b;
      tag_reg   <= head_req.tag[TAG_W-1:0];
    end
  end

  // Result register: loaded by the zero-divisor path or by the end-of-hold capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q_reg   <= '0;
      out_r_reg   <= '0;
      out_tag_reg <= '0;
      out_dbz_reg <= 1'b0;
    end else if (load_dbz) begin
      out_q_reg   <= DBZ_QUOTIENT;
      out_r_reg   <= DIV_R_W'(head_req.a);
      out_tag_reg <= head_req.tag[TAG_W-1:0];
      out_dbz_reg <= 1'b1;
    end else if (capture) begin
      out_q_reg   <= div_q;
      out_r_reg   <= div_r;
      out_tag_reg <= tag_reg;
      out_dbz_reg <= 1'b0;
    end
  end

`ifdef DIV_REM_CHECK_EN
  logic rem_err_reg;

  // Sticky flag for a remainder that is out of range for the issued divisor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_err_reg <= 1'b0;
    end else if (capture && ((div_r[DIV_R_W-1:DIV_B_W] != '0) ||
                             (div_r[DIV_B_W-1:0] >= div_b_reg))) begin
      rem_err_reg <= 1'b1;
    end
  end

  assign rem_err = rem_err_reg;
`endif

  assign in_ready  = !fifo_full;
  assign out_valid = (state_reg == DONE);
  assign div_a     = div_a_reg;
  assign div_b     = div_b_reg;
  assign out_q     = out_q_reg;
  assign out_r     = out_r_reg;
  assign out_tag   = out_tag_reg;
  assign out_dbz   = out_dbz_reg;

endmodule
